// File: rtl/rolling_average_n.sv
// -----------------------------------------------------------------------------
// rolling_average_n
//   Mean of the last 2^LOG2_WINDOW samples, kept as a circular buffer plus a
//   running sum. A slow, asynchronous sample strobe is synchronised and
//   edge-detected. Each accepted sample passes through the FSM in the order
//   IDLE -> READ -> UPDATE -> OUT. The average can be truncated or rounded
//   half-up.
//
// Parameters
//   BITS_PER_ELEM  sample width and o_ra width
//   LOG2_WINDOW    window depth W = 2^LOG2_WINDOW, legal range 1..6
//
// Ports
//   clk         system clock
//   rst         asynchronous active-high reset
//   i_data_clk  sample strobe, asynchronous to clk, rising edge submits i_value
//   i_value     sample, held stable for >= 3 clk cycles after i_data_clk rises
//   i_clear     synchronous flush, highest priority
//   i_round     0 = truncate, 1 = round half-up (sampled in OUT)
//   o_ra        current average
//   o_sum       running sum of the window
//   o_fill      number of valid samples, 0..W
//   o_valid     window full (o_fill == W)
//   o_done      one-cycle pulse when o_ra/o_sum have updated
//   o_overrun   sticky flag: a strobe arrived while busy and was dropped
// -----------------------------------------------------------------------------
module rolling_average_n #(
    parameter int BITS_PER_ELEM = 5,
    parameter int LOG2_WINDOW   = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_data_clk,
    input  logic [BITS_PER_ELEM-1:0]             i_value,
    input  logic                                 i_clear,
    input  logic                                 i_round,
    output logic [BITS_PER_ELEM-1:0]             o_ra,
    output logic [BITS_PER_ELEM+LOG2_WINDOW-1:0] o_sum,
    output logic [LOG2_WINDOW:0]                 o_fill,
    output logic                                 o_valid,
    output logic                                 o_done,
    output logic                                 o_overrun
);

    localparam int SUM_BITS = BITS_PER_ELEM + LOG2_WINDOW;
    localparam int WINDOW   = 1 << LOG2_WINDOW;

    localparam logic [LOG2_WINDOW:0] FILL_FULL  = (LOG2_WINDOW+1)'(WINDOW);
    localparam logic [SUM_BITS:0]    ROUND_HALF = (SUM_BITS+1)'(WINDOW / 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_UPDATE,
        S_OUT
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                     r_sync1;
    logic                     r_sync2;
    logic                     r_sync3;
    logic                     w_stb;

    logic [BITS_PER_ELEM-1:0] r_buf [WINDOW];
    logic [BITS_PER_ELEM-1:0] r_new;
    logic [BITS_PER_ELEM-1:0] r_old;
    logic [SUM_BITS-1:0]      r_sum;
    logic [LOG2_WINDOW-1:0]   r_ptr;
    logic [LOG2_WINDOW:0]     r_fill;
    logic [BITS_PER_ELEM-1:0] r_ra;
    logic                     r_done;
    logic                     r_overrun;

    logic                     w_full;
    logic [SUM_BITS:0]        w_sum_rnd;
    logic [BITS_PER_ELEM-1:0] w_ra_trunc;
    logic [BITS_PER_ELEM-1:0] w_ra_round;

    // Strobe synchroniser. sync3 delays sync2 by one cycle so that w_stb is a
    // single-cycle pulse on each rising edge. Because reset clears all three
    // flops, w_stb is always low while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so that
            // every flop samples the values from before the clock edge.
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= i_data_clk;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_stb = r_sync2 & ~r_sync3;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        // NOTE: assign a default first so that no path leaves the signal
        // unassigned, which would otherwise infer a latch.
        w_state_next = r_state;
        if (i_clear) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_stb) w_state_next = S_READ;
                S_READ:   w_state_next = S_UPDATE;
                S_UPDATE: w_state_next = S_OUT;
                S_OUT:    w_state_next = S_IDLE;
                default:  w_state_next = S_IDLE;
            endcase
        end
    end

    assign w_full     = (r_fill == FILL_FULL);
    assign w_sum_rnd  = {1'b0, r_sum} + ROUND_HALF;
    assign w_ra_trunc = BITS_PER_ELEM'(r_sum >> LOG2_WINDOW);
    // The running sum is at most W*(2^BITS-1), so the rounded quotient fits
    // in BITS_PER_ELEM bits and no saturation is required.
    assign w_ra_round = BITS_PER_ELEM'(w_sum_rnd >> LOG2_WINDOW);

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_new     <= '0;
            r_old     <= '0;
            r_sum     <= '0;
            r_ptr     <= '0;
            r_fill    <= '0;
            r_ra      <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else if (i_clear) begin
            // A strobe in this same cycle is discarded silently.
            r_new     <= '0;
            r_old     <= '0;
            r_sum     <= '0;
            r_ptr     <= '0;
            r_fill    <= '0;
            r_ra      <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_stb && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_stb) r_new <= i_value;
                end
                S_READ: begin
                    // Slots not yet written hold stale data. Masking them by
                    // fill count makes missing samples count as zero.
                    r_old <= w_full ? r_buf[r_ptr] : '0;
                end
                S_UPDATE: begin
                    r_sum <= r_sum + SUM_BITS'(r_new) - SUM_BITS'(r_old);
                    r_ptr <= r_ptr + LOG2_WINDOW'(1);
                    if (!w_full) r_fill <= r_fill + (LOG2_WINDOW+1)'(1);
                end
                S_OUT: begin
                    r_ra   <= i_round ? w_ra_round : w_ra_trunc;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the sample buffer is deliberately not reset. The fill mask makes
    // its stale contents invisible, so it can be implemented as plain storage.
    always_ff @(posedge clk) begin
        if ((r_state == S_UPDATE) && !i_clear) begin
            r_buf[r_ptr] <= r_new;
        end
    end

    assign o_ra      = r_ra;
    assign o_sum     = r_sum;
    assign o_fill    = r_fill;
    assign o_valid   = w_full;
    assign o_done    = r_done;
    assign o_overrun = r_overrun;

endmodule
